// File: rtl/vec3_length_if.sv
// Valid/ready stream bundle for vec3_length: a packed {z, y, x} vector in, a fixed-point
// magnitude out.
interface vec3_length_if #(
  parameter int unsigned WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [3*WIDTH-1:0] in_data;   // {z, y, x}, each a signed fixed value
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/vec3_length.sv
// Euclidean length of a signed fixed-point 3-vector via full-precision squares and a
// bit-serial restoring square root (one root bit per cycle).
module vec3_length #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  vec3_length_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned RemW = WIDTH + 4;

  if (FRAC >= WIDTH) begin : g_bad_frac
    $error("vec3_length: FRAC must be smaller than WIDTH");
  end

  typedef enum logic [2:0] {StIdle, StSquare, StSum, StRoot, StDone} state_e;

  state_e                   state_q;
  logic [WIDTH-1:0]         x_q, y_q, z_q;
  logic [2*WIDTH-1:0]       sq_x_q, sq_y_q, sq_z_q;
  logic [2*WIDTH-1:0]       rad_q;
  logic [RemW-1:0]          rem_q;
  logic [WIDTH-1:0]         root_q;
  logic [CntW-1:0]          cnt_q;
  logic                     out_valid_q;
  logic [WIDTH-1:0]         out_data_q;
  logic                     out_sat_q;

  logic signed [2*WIDTH-1:0] x_ext, y_ext, z_ext;
  logic [2*WIDTH-1:0]        sq_x, sq_y, sq_z;
  logic [RemW-1:0]           rem_sh, trial, rem_d;
  logic [WIDTH-1:0]          root_d;
  logic                      take;

  // Sign-extended squares are exact in 2*WIDTH bits, even for the most negative input.
  always_comb begin
    x_ext = {{WIDTH{x_q[WIDTH-1]}}, x_q};
    y_ext = {{WIDTH{y_q[WIDTH-1]}}, y_q};
    z_ext = {{WIDTH{z_q[WIDTH-1]}}, z_q};
    sq_x  = x_ext * x_ext;
    sq_y  = y_ext * y_ext;
    sq_z  = z_ext * z_ext;
  end

  // One restoring step: bring down the next radicand bit pair, try subtracting 4*root+1.
  always_comb begin
    rem_sh = (rem_q << 2) | RemW'(rad_q[2*WIDTH-1 -: 2]);
    trial  = {2'b00, root_q, 2'b01};
    take   = (rem_sh >= trial);
    rem_d  = take ? (rem_sh - trial) : rem_sh;
    root_d = {root_q[WIDTH-2:0], take};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      sq_x_q      <= '0;
      sq_y_q      <= '0;
      sq_z_q      <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            x_q     <= bus.in_data[WIDTH-1:0];
            y_q     <= bus.in_data[2*WIDTH-1:WIDTH];
            z_q     <= bus.in_data[3*WIDTH-1:2*WIDTH];
            state_q <= StSquare;
          end
        end
        StSquare: begin
          sq_x_q  <= sq_x;
          sq_y_q  <= sq_y;
          sq_z_q  <= sq_z;
          state_q <= StSum;
        end
        StSum: begin
          rad_q   <= sq_x_q + sq_y_q + sq_z_q;
          rem_q   <= '0;
          root_q  <= '0;
          cnt_q   <= CntW'(WIDTH);
          state_q <= StRoot;
        end
        StRoot: begin
          if (cnt_q != '0) begin
            rad_q  <= rad_q << 2;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_q - 1'b1;
          end else begin
            out_valid_q <= 1'b1;
            if (root_q[WIDTH-1]) begin
              out_data_q <= {1'b0, {(WIDTH-1){1'b1}}};
              out_sat_q  <= 1'b1;
            end else begin
              out_data_q <= root_q;
              out_sat_q  <= 1'b0;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_vec3_length.sv
// Directed, table-driven bench for vec3_length with hand-computed magnitudes plus
// backpressure and mid-operation reset sequences.
module tb_vec3_length;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned LATENCY = WIDTH + 3;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  vec3_length_if #(.WIDTH(WIDTH)) bus ();

  vec3_length #(.WIDTH(WIDTH), .FRAC(16)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x, y, z;
    logic [31:0] exp_out;
    logic        exp_sat;
    string       name;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after the acceptance edge; counts edges until out_valid and checks result.
  task automatic wait_result(input string name, input logic [31:0] exp_out, input logic exp_sat);
    int n = 0;
    bit seen = 0;
    while (n < 100 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid) seen = 1;
    end
    chk({name, " latency"}, 64'(n), 64'(LATENCY));
    chk({name, " out"}, 64'(bus.out_data), 64'(exp_out));
    chk({name, " sat"}, 64'(bus.out_sat), 64'(exp_sat));
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = {z, y, x};
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({name, " in_ready after hs"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bit seen;
    logic [31:0] held;

    tbl[0] = '{32'h0003_0000, 32'h0004_0000, 32'h0000_0000, 32'h0005_0000, 1'b0, "p345"};
    tbl[1] = '{32'hFFFD_0000, 32'hFFFC_0000, 32'h0000_0000, 32'h0005_0000, 1'b0, "p345neg"};
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, "zero"};
    tbl[3] = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_BB67, 1'b0, "sqrt3"};
    tbl[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, "satmax"};
    tbl[5] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, "satneg"};
    tbl[6] = '{32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 1'b0, "half"};
    tbl[7] = '{32'h0002_0000, 32'h0003_0000, 32'hFFFA_0000, 32'h0007_0000, 1'b0, "p236"};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out", 64'(bus.out_data), 64'd0);
    chk("rst out_sat", 64'(bus.out_sat), 64'd0);
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].x, tbl[i].y, tbl[i].z);
      chk({tbl[i].name, " in_ready busy"}, 64'(bus.in_ready), 64'd0);
      wait_result(tbl[i].name, tbl[i].exp_out, tbl[i].exp_sat);
      handshake(tbl[i].name);
    end

    // Backpressure: result must hold and new input must be ignored while DONE stalls.
    send(32'h0003_0000, 32'h0004_0000, 32'h0000_0000);
    wait_result("bp", 32'h0005_0000, 1'b0);
    held = bus.out_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid = (c == 4);
      bus.in_data  = {32'h0, 32'h0001_0000, 32'h0001_0000};
      @(posedge clk);
      #1;
      if (c == 4 || c == 9) begin
        chk("bp out stable", 64'(bus.out_data), 64'(held));
        chk("bp out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp in_ready", 64'(bus.in_ready), 64'd0);
      end
    end
    // out_ready and in_valid together: output completes, input taken the next cycle.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = {32'hFFFA_0000, 32'h0003_0000, 32'h0002_0000};
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp idle in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp idle out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp accepted", 64'(bus.in_ready), 64'd0);
    wait_result("bp next", 32'h0007_0000, 1'b0);
    handshake("bp next");

    // Reset in the middle of the root iterations aborts the operation.
    send(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    chk("midrst no result", 64'(seen), 64'd0);
    send(32'h0000_0000, 32'h0000_0000, 32'h0002_0000);
    wait_result("after rst", 32'h0002_0000, 1'b0);
    handshake("after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
